fifo_uart_tx_reader: RTL and testbench
======================================

Name: fifo_uart_tx_reader

Overview:
- Read-side consumer for the project FIFO. Pops one byte at a time from the FIFO read port and transmits it as an asynchronous serial frame: 1 start bit, 8 data bits LSB first, 1 stop bit.
- Sits between the FIFO read interface and a single uo_out pin in the tt_um top level.
- Drains the FIFO whenever the FIFO is non-empty and ena is high.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per serial bit; legal range >= 2. Bit timer width is $clog2(CLKS_PER_BIT).
- DATA_WIDTH, 8: bits per frame; fixed at 8 for this project, but kept as a parameter for the shift register and bit counter.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  design enable; gates the start of new frames only
- fifo_empty  input  1  FIFO empty flag
- fifo_rdata  input  DATA_WIDTH  FIFO read data; valid the cycle after fifo_rd is high
- fifo_rd  output  1  one-cycle pop strobe to the FIFO
- tx  output  1  serial line; idles high
- busy  output  1  high from the pop cycle through the end of the stop bit
- frames_sent  output  8  count of completed frames; wraps 255 -> 0

Behaviour:
- Reset (async, rst_n=0) forces the following immediately, including mid-frame:
  - state=IDLE, tx=1, fifo_rd=0, busy=0, frames_sent=0
  - shift register and bit/timer counters = 0
- tx is registered. fifo_rd is a combinational decode of (state==IDLE && ena && !fifo_empty).
- States:
  - IDLE: tx=1.
    - If ena && !fifo_empty: fifo_rd=1 for this cycle only; next state FETCH.
    - Otherwise stay in IDLE.
  - FETCH: fifo_rdata is captured into the shift register; next state START. fifo_rd=0.
  - START: tx=0 for exactly CLKS_PER_BIT cycles, starting the cycle after FETCH.
  - DATA: DATA_WIDTH bits, each held CLKS_PER_BIT cycles, LSB first. Shift right at each bit boundary.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
    - On the last cycle, frames_sent increments.
    - Next state IDLE.
- Frame length is 10*CLKS_PER_BIT cycles of tx activity. The minimum back-to-back period is 10*CLKS_PER_BIT + 2 cycles (IDLE pop cycle + FETCH cycle, with tx high in both).
- busy is high in FETCH, START, DATA and STOP, and in the IDLE cycle when fifo_rd=1. It is low otherwise.
- ena deasserted mid-frame: the current frame completes normally, and no further pop occurs until ena=1 again.
- fifo_empty is sampled only in IDLE. fifo_empty asserting during a frame has no effect on that frame.
- Exactly one pop per frame. fifo_rd is never asserted on two consecutive cycles, and never asserted while fifo_empty=1.
- frames_sent wraps modulo 256 with no saturation.

Optional Feature:
- Macro: FIFO_UART_TX_PARITY_EN
- Defined:
  - A PARITY state is inserted between DATA and STOP, lasting CLKS_PER_BIT cycles.
  - tx carries the even parity bit (XOR of the 8 data bits).
  - Frame length becomes 11*CLKS_PER_BIT cycles.
- Undefined: there is no PARITY state and no parity logic. Frame length is 10*CLKS_PER_BIT.

Test Plan:
- Reset and idle: rst_n=0 then 1, fifo_empty=1, ena=1 for 100 cycles -> tx=1, fifo_rd=0, busy=0, frames_sent=0 throughout.
- Single byte (CLKS_PER_BIT=4): FIFO holds 0xA5 -> exactly one fifo_rd pulse.
  - tx is low for 4 cycles starting 2 cycles after the pulse.
  - Data bits then read 1,0,1,0,0,1,0,1 (4 cycles each), followed by a 4-cycle stop bit.
  - frames_sent=1 and busy falls after the stop bit.
- Back-to-back: FIFO holds 0x00, 0xFF, 0x3C -> 3 pops spaced exactly 42 cycles apart (CLKS_PER_BIT=4).
  - Decoded bytes match in order.
  - No fourth pop occurs once fifo_empty=1.
  - frames_sent=3.
- ena gating: drop ena midway through the DATA bits of 0x81 with more bytes queued -> the frame completes intact and no further pop occurs.
  - Re-raise ena -> the next pop happens in the following IDLE cycle.
- Async reset mid-frame: assert rst_n=0 during DATA bit 3 -> tx=1 and busy=0 in the same cycle, frames_sent=0.
  - After release, the FIFO head (not yet popped again) is transmitted in full.
- Parity (macro defined, CLKS_PER_BIT=4): send 0x07 -> parity bit=1. Send 0x03 -> parity bit=0. Each frame is 44 cycles.

Source files
------------

// File: rtl/fifo_uart_tx_reader.sv
// Pops bytes from the project FIFO and sends them as 8N1 serial frames on tx.
// Define FIFO_UART_TX_PARITY_EN to add an even-parity bit between the data and stop bits.
module fifo_uart_tx_reader #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_rd,
  output logic                  tx,
  output logic                  busy,
  output logic [7:0]            frames_sent
);

  localparam int TIMER_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CNT_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]   BIT_LAST   = CNT_W'(DATA_WIDTH - 1);

`ifdef FIFO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t                r_state;
  state_t                w_stateNext;
  logic [TIMER_W-1:0]    r_timer;
  logic [CNT_W-1:0]      r_bitCnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_shifted;
  logic                  r_tx;
  logic [7:0]            r_frames;
  logic                  w_pop;
  logic                  w_timerLast;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                  r_parity;
`endif

  assign w_timerLast = (r_timer == TIMER_LAST);
  assign w_shifted   = r_shift >> 1;

  // rst_n is folded into the pop decode so the FIFO is never popped while held in reset.
  always_comb begin
    w_stateNext = r_state;
    w_pop       = (r_state == S_IDLE) && ena && !fifo_empty && rst_n;
    case (r_state)
      S_IDLE:   if (w_pop) w_stateNext = S_FETCH;
      S_FETCH:  w_stateNext = S_START;
      S_START:  if (w_timerLast) w_stateNext = S_DATA;
      S_DATA: begin
        if (w_timerLast && (r_bitCnt == BIT_LAST)) begin
`ifdef FIFO_UART_TX_PARITY_EN
          w_stateNext = S_PARITY;
`else
          w_stateNext = S_STOP;
`endif
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      S_PARITY: if (w_timerLast) w_stateNext = S_STOP;
`endif
      S_STOP:   if (w_timerLast) w_stateNext = S_IDLE;
      default:  w_stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_stateNext;
  end

  // r_tx is loaded one cycle ahead with the level of the bit about to start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer  <= '0;
      r_bitCnt <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
      r_frames <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_timer  <= '0;
          r_bitCnt <= '0;
          r_tx     <= 1'b1;
        end
        S_FETCH: begin
          r_shift <= fifo_rdata;
`ifdef FIFO_UART_TX_PARITY_EN
          r_parity <= ^fifo_rdata;
`endif
          r_timer <= '0;
          r_tx    <= 1'b0;
        end
        S_START: begin
          if (w_timerLast) begin
            r_timer  <= '0;
            r_bitCnt <= '0;
            r_tx     <= r_shift[0];
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_DATA: begin
          if (w_timerLast) begin
            r_timer <= '0;
            r_shift <= w_shifted;
            if (r_bitCnt == BIT_LAST) begin
              r_bitCnt <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
              r_tx <= r_parity;
`else
              r_tx <= 1'b1;
`endif
            end else begin
              r_bitCnt <= r_bitCnt + 1'b1;
              r_tx     <= w_shifted[0];
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_timerLast) begin
            r_timer <= '0;
            r_tx    <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (w_timerLast) begin
            r_timer  <= '0;
            r_frames <= r_frames + 8'd1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: r_timer <= '0;
      endcase
    end
  end

  assign fifo_rd     = w_pop;
  assign busy        = (r_state != S_IDLE) || w_pop;
  assign tx          = r_tx;
  assign frames_sent = r_frames;

endmodule

// File: tb/tb_fifo_uart_tx_reader.sv
// Self-checking bench: a queue-based FIFO model feeds the reader and each frame is
// compared bit-by-bit against the serial format derived from the popped byte.
module tb_fifo_uart_tx_reader;

  localparam int CLKS = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int PERIOD = NBITS * CLKS + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_rdata = 8'h00;
  logic       fifo_rd;
  logic       tx;
  logic       busy;
  logic [7:0] frames_sent;

  always #5 clk = ~clk;

  fifo_uart_tx_reader #(.CLKS_PER_BIT(CLKS), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata), .fifo_rd(fifo_rd), .tx(tx), .busy(busy),
    .frames_sent(frames_sent)
  );

  int         checks = 0;
  int         failures = 0;
  logic [7:0] q[$];
  logic [7:0] pendingByte = 8'h00;
  bit         pending = 0;
  logic       sTx = 1'b1, sRd = 1'b0, sBusy = 1'b0, prevRd = 1'b0;
  logic [7:0] sFrames = 8'h00;
  int         cycleNo = 0;
  int         popTimes[$];
  logic [7:0] expFrames = 8'h00;
  logic [7:0] vals[250];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pushByte(input logic [7:0] b);
    q.push_back(b);
    fifo_empty = 1'b0;
  endtask

  // Sample the current cycle, model the FIFO pop, then advance to the next mid-cycle point.
  task automatic step();
    #1;
    sTx = tx; sRd = fifo_rd; sBusy = busy; sFrames = frames_sent;
    if (sRd) begin
      checkOutput("rd_back_to_back", 32'(prevRd), 32'd0);
      checkOutput("rd_while_empty", 32'(fifo_empty), 32'd0);
      popTimes.push_back(cycleNo);
      if (q.size() > 0) begin
        pendingByte = q.pop_front();
        pending = 1;
      end
    end
    prevRd = sRd;
    cycleNo++;
    @(negedge clk);
    if (pending) begin
      fifo_rdata = pendingByte;
      pending = 0;
    end else begin
      fifo_rdata = 8'($urandom);
    end
    fifo_empty = (q.size() == 0);
  endtask

  task automatic quietFor(input int n, input string tag);
    int pops = 0;
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (sRd) pops++;
      if (sTx !== 1'b1 || sBusy !== 1'b0 || sFrames !== expFrames) bad++;
    end
    checkOutput({tag, "_pops"}, 32'(pops), 32'd0);
    checkOutput({tag, "_line"}, 32'(bad), 32'd0);
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit nextPop, input int dropEnaBit);
    int n = 0;
    logic [NBITS-1:0] bits;
    logic obsTx, obsBusy;
    while (!sRd && n < 500) begin
      step();
      n++;
    end
    checkOutput("pop_seen", 32'(sRd), 32'd1);
    checkOutput("busy_pop", 32'(sBusy), 32'd1);
    step();
    checkOutput("fetch_tx", 32'(sTx), 32'd1);
    checkOutput("fetch_busy", 32'(sBusy), 32'd1);
    checkOutput("frames_hold", 32'(sFrames), 32'(expFrames));
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = b[i];
`ifdef FIFO_UART_TX_PARITY_EN
    bits[9] = ^b;
`endif
    bits[NBITS-1] = 1'b1;
    for (int k = 0; k < NBITS; k++) begin
      if (k == dropEnaBit) ena = 1'b0;
      obsTx = bits[k];
      obsBusy = 1'b1;
      for (int c = 0; c < CLKS; c++) begin
        step();
        if (sTx !== bits[k]) obsTx = sTx;
        if (sBusy !== 1'b1) obsBusy = sBusy;
      end
      checkOutput($sformatf("byte%02h_bit%0d_tx", b, k), 32'(obsTx), 32'(bits[k]));
      checkOutput($sformatf("byte%02h_bit%0d_busy", b, k), 32'(obsBusy), 32'd1);
    end
    expFrames = expFrames + 8'd1;
    step();
    checkOutput("frames_sent", 32'(sFrames), 32'(expFrames));
    checkOutput("next_pop", 32'(sRd), 32'(nextPop));
    checkOutput("busy_after", 32'(sBusy), 32'(nextPop));
    checkOutput("tx_after", 32'(sTx), 32'd1);
  endtask

  initial begin
    int n;
    @(negedge clk);
    rst_n = 1'b0; ena = 1'b1; fifo_empty = 1'b1;
    #1;
    checkOutput("reset_tx", 32'(tx), 32'd1);
    checkOutput("reset_rd", 32'(fifo_rd), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_frames", 32'(frames_sent), 32'd0);
    step(); step();
    rst_n = 1'b1;
    quietFor(100, "idle");

    // Single byte
    pushByte(8'hA5);
    applyStimulus(8'hA5, 0, -1);
    quietFor(20, "after_a5");

    // Back-to-back frames
    popTimes.delete();
    pushByte(8'h00); pushByte(8'hFF); pushByte(8'h3C);
    applyStimulus(8'h00, 1, -1);
    applyStimulus(8'hFF, 1, -1);
    applyStimulus(8'h3C, 0, -1);
    checkOutput("b2b_pop_count", 32'(popTimes.size()), 32'd3);
    checkOutput("b2b_spacing1", 32'(popTimes[1] - popTimes[0]), 32'(PERIOD));
    checkOutput("b2b_spacing2", 32'(popTimes[2] - popTimes[1]), 32'(PERIOD));
    quietFor(50, "after_b2b");

    // ena dropped mid-DATA: frame finishes, queue held until ena returns
    pushByte(8'h81); pushByte(8'h11); pushByte(8'h22);
    applyStimulus(8'h81, 0, 3);
    quietFor(30, "ena_low");
    checkOutput("queue_held", 32'(q.size()), 32'd2);
    ena = 1'b1;
    step();
    checkOutput("reenable_pop", 32'(sRd), 32'd1);
    applyStimulus(8'h11, 1, -1);
    applyStimulus(8'h22, 0, -1);

    // Async reset during data bit 3 (bit 3 of 0x52 is 0, so tx must jump high)
    pushByte(8'h52); pushByte(8'h77);
    n = 0;
    while (!sRd && n < 500) begin
      step();
      n++;
    end
    checkOutput("rst_test_pop", 32'(sRd), 32'd1);
    for (int i = 0; i < 1 + CLKS + 3 * CLKS + 2; i++) step();
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_tx", 32'(tx), 32'd1);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_rd", 32'(fifo_rd), 32'd0);
    checkOutput("midreset_frames", 32'(frames_sent), 32'd0);
    expFrames = 8'h00;
    step(); step();
    rst_n = 1'b1;
    applyStimulus(8'h77, 0, -1);

    // Parity-sensitive bytes
    popTimes.delete();
    pushByte(8'h07); pushByte(8'h03);
    applyStimulus(8'h07, 1, -1);
    applyStimulus(8'h03, 0, -1);
    checkOutput("par_spacing", 32'(popTimes[1] - popTimes[0]), 32'(PERIOD));

    // Random bytes with random idle gaps
    for (int i = 0; i < 6; i++) begin
      logic [7:0] r;
      r = 8'($urandom);
      pushByte(r);
      applyStimulus(r, 0, -1);
      n = $urandom_range(0, 5);
      for (int j = 0; j < n; j++) step();
    end

    // Long burst carries frames_sent through its 255 -> 0 wrap
    for (int i = 0; i < 250; i++) begin
      vals[i] = 8'($urandom);
      pushByte(vals[i]);
    end
    for (int i = 0; i < 250; i++) applyStimulus(vals[i], i < 249, -1);
    quietFor(20, "final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
